// File: rtl/ibr_opmode_ctrl.sv
// rtl/ibr_opmode_ctrl.sv - block-cipher mode-of-operation controller (ECB/CBC/OFB/CTR)
// Optional CFB mode (SOM=4) is built only when IBR_OPMODE_CFB_EN is defined.
module ibr_opmode_ctrl #(
  parameter int BW    = 128,
  parameter int CTR_W = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_enable,
  input  logic          i_encrypt,
  input  logic [2:0]    i_som,
  input  logic          i_fb,
  input  logic [BW-1:0] i_iv,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [BW-1:0] i_in_data,
  output logic          o_core_start,
  output logic          o_core_encrypt,
  output logic [BW-1:0] o_core_data,
  input  logic          i_core_done,
  input  logic [BW-1:0] i_core_result,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [BW-1:0] o_out_data,
  output logic          o_ctr_wrap,
  output logic          o_mode_err
);

  localparam logic [2:0] MODE_ECB = 3'd0;
  localparam logic [2:0] MODE_CBC = 3'd1;
  localparam logic [2:0] MODE_OFB = 3'd2;
  localparam logic [2:0] MODE_CTR = 3'd3;
`ifdef IBR_OPMODE_CFB_EN
  localparam logic [2:0] MODE_CFB = 3'd4;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CORE, S_OUT} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_accept;
  logic          w_take;
  logic          w_hs;
  logic          w_legal;

  logic [BW-1:0] r_chain;
  logic [BW-1:0] r_data;
  logic          r_enc;
  logic [2:0]    r_som;
  logic          r_core_start;
  logic          r_core_enc;
  logic [BW-1:0] r_core_data;
  logic          r_out_valid;
  logic [BW-1:0] r_out_data;
  logic          r_ctr_wrap;
  logic          r_mode_err;

  logic [BW-1:0] w_chain_in;
  logic [BW-1:0] w_core_d;
  logic          w_core_e;
  logic [BW-1:0] w_res;
  logic [BW-1:0] w_chain_nxt;
  logic          w_wrap;
  logic [CTR_W-1:0] w_ctr_lo;
  logic [BW-1:0] w_ctr_next;

`ifdef IBR_OPMODE_CFB_EN
  assign w_legal = (i_som <= MODE_CFB);
`else
  assign w_legal = (i_som <= MODE_CTR);
`endif

  assign w_chain_in = i_fb ? i_iv : r_chain;

  // Only the low CTR_W bits count; the upper part of the chain is a fixed nonce.
  assign w_ctr_lo = r_chain[CTR_W-1:0] + CTR_W'(1);
  generate
    if (CTR_W == BW) begin : g_ctr_full
      assign w_ctr_next = w_ctr_lo;
    end else begin : g_ctr_part
      assign w_ctr_next = {r_chain[BW-1:CTR_W], w_ctr_lo};
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_take      = 1'b0;
    w_hs        = 1'b0;
    if (!i_enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (i_in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = w_legal ? S_CORE : S_OUT;
        end
        S_CORE: if (i_core_done) begin
          w_take      = 1'b1;
          w_state_nxt = S_OUT;
        end
        S_OUT: if (i_out_ready) begin
          w_hs        = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_core_d = i_in_data;
    w_core_e = i_encrypt;
    case (i_som)
      MODE_CBC: if (i_encrypt) w_core_d = i_in_data ^ w_chain_in;
      MODE_OFB, MODE_CTR: begin
        w_core_d = w_chain_in;
        w_core_e = 1'b1;
      end
`ifdef IBR_OPMODE_CFB_EN
      MODE_CFB: begin
        w_core_d = w_chain_in;
        w_core_e = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    w_res       = i_core_result;
    w_chain_nxt = r_chain;
    w_wrap      = 1'b0;
    case (r_som)
      MODE_CBC: begin
        if (r_enc) begin
          w_chain_nxt = i_core_result;
        end else begin
          w_res       = i_core_result ^ r_chain;
          w_chain_nxt = r_data;
        end
      end
      MODE_OFB: begin
        w_res       = i_core_result ^ r_data;
        w_chain_nxt = i_core_result;
      end
      MODE_CTR: begin
        w_res       = i_core_result ^ r_data;
        w_chain_nxt = w_ctr_next;
        w_wrap      = &r_chain[CTR_W-1:0];
      end
`ifdef IBR_OPMODE_CFB_EN
      MODE_CFB: begin
        w_res       = i_core_result ^ r_data;
        w_chain_nxt = r_enc ? (i_core_result ^ r_data) : r_data;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_chain      <= '0;
      r_data       <= '0;
      r_enc        <= 1'b0;
      r_som        <= 3'd0;
      r_core_start <= 1'b0;
      r_core_enc   <= 1'b0;
      r_core_data  <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_ctr_wrap   <= 1'b0;
      r_mode_err   <= 1'b0;
    end else begin
      r_core_start <= 1'b0;
      if (!i_enable) begin
        r_out_valid <= 1'b0;
        r_ctr_wrap  <= 1'b0;
        r_mode_err  <= 1'b0;
      end else if (w_accept) begin
        r_data <= i_in_data;
        r_enc  <= i_encrypt;
        r_som  <= i_som;
        if (w_legal) begin
          r_chain      <= w_chain_in;
          r_core_data  <= w_core_d;
          r_core_enc   <= w_core_e;
          r_core_start <= 1'b1;
        end else begin
          // Illegal mode bypasses the core and echoes the block back flagged.
          r_out_data  <= i_in_data;
          r_mode_err  <= 1'b1;
          r_ctr_wrap  <= 1'b0;
          r_out_valid <= 1'b1;
        end
      end else if (w_take) begin
        r_out_data  <= w_res;
        r_chain     <= w_chain_nxt;
        r_ctr_wrap  <= w_wrap;
        r_out_valid <= 1'b1;
      end else if (w_hs) begin
        r_out_valid <= 1'b0;
        r_ctr_wrap  <= 1'b0;
        r_mode_err  <= 1'b0;
      end
    end
  end

  assign o_in_ready     = (r_state == S_IDLE) && i_enable && !i_rst;
  assign o_core_start   = r_core_start;
  assign o_core_encrypt = r_core_enc;
  assign o_core_data    = r_core_data;
  assign o_out_valid    = r_out_valid;
  assign o_out_data     = r_out_data;
  assign o_ctr_wrap     = r_ctr_wrap;
  assign o_mode_err     = r_mode_err;

endmodule

// File: tb/tb_ibr_opmode_ctrl.sv
// tb/tb_ibr_opmode_ctrl.sv - directed self-checking bench for ibr_opmode_ctrl
module tb_ibr_opmode_ctrl;

  localparam int BW    = 64;
  localparam int CTR_W = 8;
  localparam int L     = 4;

  localparam logic [2:0] ECB = 3'd0;
  localparam logic [2:0] CBC = 3'd1;
  localparam logic [2:0] OFB = 3'd2;
  localparam logic [2:0] CTR = 3'd3;
  localparam logic [2:0] CFB = 3'd4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b1;
  logic          encrypt = 1'b0;
  logic [2:0]    som = 3'd0;
  logic          fb = 1'b0;
  logic [BW-1:0] iv = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_data = '0;
  logic          core_start;
  logic          core_encrypt;
  logic [BW-1:0] core_data;
  logic          core_done;
  logic [BW-1:0] core_result;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [BW-1:0] out_data;
  logic          ctr_wrap;
  logic          mode_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int            st_cnt = 0;
  int            start_cnt = 0;
  logic [BW-1:0] st_data = '0;
  logic          st_enc = 1'b0;

  ibr_opmode_ctrl #(.BW(BW), .CTR_W(CTR_W)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_enable       (enable),
    .i_encrypt      (encrypt),
    .i_som          (som),
    .i_fb           (fb),
    .i_iv           (iv),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .i_in_data      (in_data),
    .o_core_start   (core_start),
    .o_core_encrypt (core_encrypt),
    .o_core_data    (core_data),
    .i_core_done    (core_done),
    .i_core_result  (core_result),
    .o_out_valid    (out_valid),
    .i_out_ready    (out_ready),
    .o_out_data     (out_data),
    .o_ctr_wrap     (ctr_wrap),
    .o_mode_err     (mode_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Identity core stub: result equals the started block, done L cycles after start.
  always @(posedge clk) begin
    if (core_start) begin
      st_cnt    <= L;
      st_data   <= core_data;
      st_enc    <= core_encrypt;
      start_cnt <= start_cnt + 1;
    end else if (st_cnt > 0) begin
      st_cnt <= st_cnt - 1;
    end
  end
  assign core_done   = (st_cnt == 1);
  assign core_result = st_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic enc, input logic [2:0] s, input logic f,
                      input logic [BW-1:0] v, input logic [BW-1:0] d, output int t0);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_in_ready", 64'(in_ready), 64'd1);
    encrypt  = enc;
    som      = s;
    fb       = f;
    iv       = v;
    in_data  = d;
    in_valid = 1'b1;
    t0       = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int t);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) check("out_valid_timeout", 64'd0, 64'd1);
    t = cyc;
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
  endtask

  task automatic do_block(input string tag, input logic enc, input logic [2:0] s,
                          input logic f, input logic [BW-1:0] v, input logic [BW-1:0] d,
                          input logic [BW-1:0] exp_core, input logic exp_dir,
                          input logic [BW-1:0] exp_out, input logic exp_wrap);
    int t0, t1;
    send(enc, s, f, v, d, t0);
    wait_out(t1);
    check({tag, "_latency"}, 64'(t1 - t0), 64'd6);
    check({tag, "_core_data"}, st_data, exp_core);
    check({tag, "_core_dir"}, 64'(st_enc), 64'(exp_dir));
    check({tag, "_out_data"}, out_data, exp_out);
    check({tag, "_ctr_wrap"}, 64'(ctr_wrap), 64'(exp_wrap));
    check({tag, "_mode_err"}, 64'(mode_err), 64'd0);
    handshake(tag);
  endtask

  initial begin
    int t0, t1, seen, bad, rdy, cnt0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
    end
    check("rst_core_start", 64'(core_start), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_flags", {62'd0, ctr_wrap, mode_err}, 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    do_block("cbc1", 1'b1, CBC, 1'b1, 64'h01, 64'h10, 64'h11, 1'b1, 64'h11, 1'b0);
    do_block("cbc2", 1'b1, CBC, 1'b0, 64'h00, 64'h22, 64'h33, 1'b1, 64'h33, 1'b0);

    send(1'b1, CBC, 1'b0, 64'h00, 64'h40, t0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    enable = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("en_drop_no_valid", 64'(seen), 64'd0);
    check("en_drop_in_ready_low", 64'(in_ready), 64'd0);
    enable = 1'b1;
    #1;
    check("en_drop_idle", 64'(in_ready), 64'd1);
    do_block("cbc3", 1'b1, CBC, 1'b0, 64'h00, 64'h01, 64'h32, 1'b1, 64'h32, 1'b0);

    do_block("ecb_dec", 1'b0, ECB, 1'b0, 64'h00, 64'h77, 64'h77, 1'b0, 64'h77, 1'b0);

    do_block("ctr1", 1'b1, CTR, 1'b1, 64'hABABABABABABABFF, 64'h0,
             64'hABABABABABABABFF, 1'b1, 64'hABABABABABABABFF, 1'b1);
    do_block("ctr2", 1'b1, CTR, 1'b0, 64'h0, 64'h0,
             64'hABABABABABABAB00, 1'b1, 64'hABABABABABABAB00, 1'b0);

    out_ready = 1'b0;
    send(1'b1, OFB, 1'b1, 64'h1234, 64'hFF, t0);
    wait_out(t1);
    check("ofb_latency", 64'(t1 - t0), 64'd6);
    check("ofb_out_data", out_data, 64'h12CB);
    cnt0 = start_cnt;
    encrypt  = 1'b1;
    som      = OFB;
    fb       = 1'b0;
    in_data  = 64'h0;
    in_valid = 1'b1;
    bad = 0;
    rdy = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_data !== 64'h12CB || !out_valid) bad++;
      if (in_ready) rdy++;
    end
    check("ofb_hold_stable", 64'(bad), 64'd0);
    check("ofb_hold_in_ready", 64'(rdy), 64'd0);
    check("ofb_hold_no_start", 64'(start_cnt), 64'(cnt0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("ofb_hs_valid_drop", 64'(out_valid), 64'd0);
    check("ofb_resume_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ofb_resume_start", 64'(core_start), 64'd1);
    wait_out(t1);
    check("ofb2_core_data", st_data, 64'h1234);
    check("ofb2_out_data", out_data, 64'h1234);
    handshake("ofb2");

    cnt0 = start_cnt;
    send(1'b1, CFB, 1'b0, 64'h0, 64'h5A, t0);
    wait_out(t1);
    check("ill_latency", 64'(t1 - t0), 64'd1);
    check("ill_out_data", out_data, 64'h5A);
    check("ill_mode_err", 64'(mode_err), 64'd1);
    handshake("ill");
    check("ill_mode_err_clear", 64'(mode_err), 64'd0);
    @(posedge clk); #1;
    check("ill_no_core_start", 64'(start_cnt), 64'(cnt0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
